mul_div_unit: RTL and testbench

- Iterative multi-cycle integer multiply/divide unit for the execute stage.
- Sits beside the single-cycle ALU and shift-merge logic; the pipeline stalls on `busy`.
- WIDTH-parametrised. Radix-2: one shift-add or restoring-subtract step per cycle.
- Start/done handshake and a kill input for pipeline flush.

---
 rtl/mul_div_unit_pkg.sv | 25 ++
 rtl/mul_div_step.sv | 32 +++
 rtl/mul_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encoding and op decode helpers for the iterative multiply/divide unit.
package mul_div_unit_pkg;

  localparam logic [1:0] MD_OP_MULU = 2'd0;
  localparam logic [1:0] MD_OP_MULS = 2'd1;
  localparam logic [1:0] MD_OP_DIVU = 2'd2;
  localparam logic [1:0] MD_OP_DIVS = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One radix-2 iteration: shift-right-add for multiply, restoring shift-left-subtract for divide.
module mul_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             is_div_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opr_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum = {1'b0, acc_i};
    if (opr_i[0]) sum = {1'b0, acc_i} + {1'b0, dvs_i};
    // Partial remainder needs WIDTH+1 bits before the subtract; diff MSB is the borrow.
    shl  = {acc_i, opr_i[WIDTH-1]};
    diff = {1'b0, shl} - {2'b00, dvs_i};
    if (is_div_i) begin
      acc_o = diff[WIDTH+1] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
      opr_o = {opr_i[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      acc_o = sum[WIDTH:1];
      opr_o = {sum[0], opr_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide (MULU/MULS/DIVU/DIVS) with start/done handshake and kill.
// Optional MULDIV_EARLY_TERM_EN: multiply exits RUN once the remaining multiplier bits are zero.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter  int WIDTH = `WORD_LENGTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             err
);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opr_q, opr_d;
  logic [WIDTH-1:0] mcd_q, mcd_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             err_q, err_d;

  logic             div_zero, div_ovf, special;
  logic             sgn_op, early_exit;
  logic [WIDTH-1:0] a_mag, b_mag, step_acc, step_opr, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;

  assign div_zero = op_is_div(op) && (b == '0);
  assign div_ovf  = (op == MD_OP_DIVS) && (a == MIN_VAL) && (b == '1);
  assign special  = div_zero || div_ovf;

  assign sgn_op   = op_is_signed(op_q);
  assign a_mag    = (sgn_op && opr_q[WIDTH-1]) ? -opr_q : opr_q;
  assign b_mag    = (sgn_op && mcd_q[WIDTH-1]) ? -mcd_q : mcd_q;
  assign prod_fix = neg_q ? -{acc_q, opr_q} : {acc_q, opr_q};
  assign quo_fix  = neg_q ? -opr_q : opr_q;
  assign rem_fix  = rneg_q ? -acc_q : acc_q;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opr_i    (opr_q),
    .dvs_i    (mcd_q),
    .is_div_i (op_is_div(op_q)),
    .acc_o    (step_acc),
    .opr_o    (step_opr)
  );

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0]   rem_mask;
  logic [2*WIDTH-1:0] aligned;
  // Remaining shifts are folded into the exiting step so multiplier 0/1 finishes in 4 cycles.
  assign rem_mask   = ~({WIDTH{1'b1}} << (cnt_q - CNT_ONE));
  assign early_exit = (state_q == RUN) && !op_is_div(op_q) && (((opr_q >> 1) & rem_mask) == '0);
  assign aligned    = {step_acc, step_opr} >> (cnt_q - CNT_ONE);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = special ? DONE : PREP;
        PREP:    state_d = RUN;
        RUN:     if ((cnt_q == CNT_ONE) || early_exit) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
    done = (state_q == DONE);
  end

  always_comb begin
    acc_d    = acc_q;
    opr_d    = opr_q;
    mcd_d    = mcd_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start && !kill) begin
        op_d  = op;
        opr_d = a;
        mcd_d = b;
        if (div_zero) begin
          res_hi_d = a;
          res_lo_d = '1;
          err_d    = 1'b1;
        end else if (div_ovf) begin
          res_hi_d = '0;
          res_lo_d = MIN_VAL;
          err_d    = 1'b1;
        end
      end
      PREP: begin
        acc_d  = '0;
        cnt_d  = CNT_INIT;
        neg_d  = sgn_op && (opr_q[WIDTH-1] ^ mcd_q[WIDTH-1]);
        rneg_d = sgn_op && opr_q[WIDTH-1];
        // Divide keeps dividend in opr; multiply puts the multiplier there.
        opr_d  = op_is_div(op_q) ? a_mag : b_mag;
        mcd_d  = op_is_div(op_q) ? b_mag : a_mag;
      end
      RUN: begin
        acc_d = step_acc;
        opr_d = step_opr;
        cnt_d = cnt_q - CNT_ONE;
`ifdef MULDIV_EARLY_TERM_EN
        if (early_exit) {acc_d, opr_d} = aligned;
`endif
      end
      FIX: if (!kill) begin
        err_d = 1'b0;
        if (op_is_div(op_q)) begin
          res_hi_d = rem_fix;
          res_lo_d = quo_fix;
        end else begin
          res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
          res_lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      opr_q    <= '0;
      mcd_q    <= '0;
      op_q     <= MD_OP_MULU;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opr_q    <= opr_d;
      mcd_q    <= mcd_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
    end
  end

  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: hand-computed results, latency, kill, reset and busy-start cases.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_SMALL = 4;
`else
  localparam int LAT_SMALL = 35;
`endif

  logic         clk = 1'b0;
  logic         rst, start, kill;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, err;
  logic [W-1:0] res_hi, res_lo;

  int total = 0;
  int bad   = 0;
  int lat;
  int done_cnt;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start on a falling edge (cycle 0) and count cycles until done, bounded at 200.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int l);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    l = 0;
    while (l < 200) begin
      @(negedge clk);
      start = 1'b0;
      l++;
      if (done) break;
    end
  endtask

  task automatic chk_res(input string tag, input int l, input int exp_l,
                         input logic [W-1:0] hi, input logic [W-1:0] lo, input logic e);
    chk({tag, " latency"}, 64'(l), 64'(exp_l));
    chk({tag, " res_hi"}, 64'(res_hi), 64'(hi));
    chk({tag, " res_lo"}, 64'(res_lo), 64'(lo));
    chk({tag, " err"}, 64'(err), 64'(e));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset res_hi", 64'(res_hi), 64'(0));
    chk("reset res_lo", 64'(res_lo), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    rst = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    chk_res("mulu max", lat, 35, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    chk("done pulse width", 64'(done), 64'(0));
    chk("busy after done", 64'(busy), 64'(0));
    chk("hold res_lo", 64'(res_lo), 64'h1);

    run_op(2'd1, 32'hFFFF_FFFD, 32'd7, lat);
    chk_res("muls -3*7", lat, 35, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat);
    chk_res("divs -7/2", lat, 35, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    run_op(2'd3, 32'd7, 32'hFFFF_FFFE, lat);
    chk_res("divs 7/-2", lat, 35, 32'd1, 32'hFFFF_FFFD, 1'b0);

    run_op(2'd2, 32'd100, 32'd7, lat);
    chk_res("divu 100/7", lat, 35, 32'd2, 32'd14, 1'b0);

    run_op(2'd2, 32'd100, 32'd0, lat);
    chk_res("divu by zero", lat, 1, 32'd100, 32'hFFFF_FFFF, 1'b1);

    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    chk_res("divs overflow", lat, 1, 32'd0, 32'h8000_0000, 1'b1);

    // Start pulsed mid-operation with a divide-by-zero that would finish at once if accepted.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'h8000_0001;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (lat == 5) begin
        start = 1'b1; op = 2'd2; a = 32'd9; b = 32'd0;
      end
      if (done) break;
    end
    chk_res("start while busy", lat, 35, 32'd1, 32'h8000_0003, 1'b0);

    // Kill at cycle 10, then a fresh start on the cycle after.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
    done_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    if (done) done_cnt++;
    chk("kill no done", 64'(done_cnt), 64'(0));
    chk("kill busy low", 64'(busy), 64'(0));
    chk("kill res_lo kept", 64'(res_lo), 64'h8000_0003);
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (done) break;
    end
    chk_res("restart after kill", lat, 35, 32'd0, 32'd30, 1'b0);

    // Kill and start together in IDLE: start must be dropped.
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 2'd2; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill+start busy", 64'(busy), 64'(0));
    chk("kill+start done", 64'(done), 64'(0));
    chk("kill+start err", 64'(err), 64'(0));

    run_op(2'd0, 32'd5, 32'd1, lat);
    chk_res("mulu 5*1", lat, LAT_SMALL, 32'd0, 32'd5, 1'b0);

    // Reset mid-operation returns everything to zero and no done follows.
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'hFFFF_FFFF; b = 32'd2;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", 64'(busy), 64'(0));
    chk("mid rst res_lo", 64'(res_lo), 64'(0));
    chk("mid rst res_hi", 64'(res_hi), 64'(0));
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("mid rst no done", 64'(done_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
